// File: rtl/gate_cell_arbiter_pkg.sv
// Shared constants and types for the gate-cell arbiter: opcodes, FSM states, C1 pin bundle.
package gate_cell_arbiter_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned OP_W  = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOR  = 3'd2,
    OP_XOR  = 3'd3,
    OP_NOT  = 3'd4,
    OP_BUF  = 3'd5,
    OP_ILL6 = 3'd6,
    OP_ILL7 = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // C1 cell configuration pins
  typedef struct packed {
    logic a0;
    logic a1;
    logic sa;
    logic b0;
    logic b1;
    logic sb;
    logic s0;
    logic s1;
  } c1_cfg_t;

  // Request captured at grant time
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [OP_W-1:0] op;
    logic            a;
    logic            b;
  } req_t;

  // Round-robin successor, wraps 3 -> 0
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] id);
    return id + ID_W'(1);
  endfunction

endpackage

// File: rtl/gate_cell_cfg.sv
// C1 logic cell plus the opcode-to-pin mapping that drives it (combinational only).
module gate_c1_cell
  import gate_cell_arbiter_pkg::*;
(
  input  c1_cfg_t i_cfg,
  output logic    o_y_c
);

  logic w_mux_a;
  logic w_mux_b;

  // Two input muxes followed by an output mux selected by S0|S1
  assign w_mux_a = i_cfg.sa ? i_cfg.a1 : i_cfg.a0;
  assign w_mux_b = i_cfg.sb ? i_cfg.b1 : i_cfg.b0;
  assign o_y_c   = (i_cfg.s0 | i_cfg.s1) ? w_mux_b : w_mux_a;

endmodule

module gate_cell_cfg
  import gate_cell_arbiter_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  input  logic            i_a,
  input  logic            i_b,
  output logic            o_y_c,
  output logic            o_err_c
);

  c1_cfg_t w_cfg;

  // Map opcode and operands onto C1 pins; illegal opcodes leave all pins low (y=0)
  always_comb begin
    w_cfg   = '0;
    o_err_c = 1'b0;
    case (i_op)
      OP_AND: begin w_cfg.sa = i_a; w_cfg.a1 = i_b; end
      OP_OR:  begin w_cfg.sa = i_a; w_cfg.a0 = i_b; w_cfg.a1 = 1'b1; end
      OP_NOR: begin w_cfg.s1 = 1'b1; w_cfg.sb = i_a; w_cfg.b0 = ~i_b; end
      OP_XOR: begin w_cfg.s0 = 1'b1; w_cfg.sb = i_a; w_cfg.b0 = i_b; w_cfg.b1 = ~i_b; end
      OP_NOT: begin w_cfg.sa = i_a; w_cfg.a0 = 1'b1; end
      OP_BUF: begin w_cfg.sa = i_a; w_cfg.a1 = 1'b1; end
      default: o_err_c = 1'b1;
    endcase
  end

  gate_c1_cell u_c1 (
    .i_cfg (w_cfg),
    .o_y_c (o_y_c)
  );

endmodule

// File: rtl/gate_cell_arbiter.sv
// Round-robin arbiter of four requesters sharing one C1 gate cell; IDLE/EVAL/RESP sequencing.
module gate_cell_arbiter
  import gate_cell_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*OP_W-1:0] req_op,
  input  logic [N_REQ-1:0]      req_a,
  input  logic [N_REQ-1:0]      req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  state_e           r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  req_t             r_req;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic             r_rsp_data;
  logic             r_rsp_err;
  logic             r_busy;
  logic [CNT_W-1:0] r_op_count;

  logic             w_found;
  logic [ID_W-1:0]  w_win;
  logic [ID_W-1:0]  w_idx;
  logic [OP_W-1:0]  w_win_op;
  logic             w_cell_y;
  logic             w_cell_err;

  // Round-robin search for the first valid requester starting at r_rr_ptr
  always_comb begin
    w_found  = 1'b0;
    w_win    = '0;
    w_idx    = '0;
    w_win_op = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_idx = r_rr_ptr + ID_W'(k);
      if (!w_found && req_valid[w_idx]) begin
        w_found  = 1'b1;
        w_win    = w_idx;
        w_win_op = req_op[w_idx*OP_W +: OP_W];
      end
    end
  end

  // Grant strobe only in IDLE; gated by rst_n so it drops immediately in reset
  assign req_ready = (rst_n && (r_state == ST_IDLE) && w_found) ? (N_REQ'(1) << w_win) : '0;

  gate_cell_cfg u_cfg (
    .i_op    (r_req.op),
    .i_a     (r_req.a),
    .i_b     (r_req.b),
    .o_y_c   (w_cell_y),
    .o_err_c (w_cell_err)
  );

  // Control FSM: capture on grant, evaluate for one cycle, hold response until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_req       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_req    <= '{id: w_win, op: w_win_op, a: req_a[w_win], b: req_b[w_win]};
            r_rr_ptr <= rr_next(w_win);
            r_busy   <= 1'b1;
            r_state  <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          r_rsp_data  <= w_cell_y;
          r_rsp_err   <= w_cell_err;
          r_rsp_id    <= r_req.id;
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            if (r_op_count != {CNT_W{1'b1}}) begin
              r_op_count <= r_op_count + CNT_W'(1);
            end
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_gate_cell_arbiter.sv
// Bench for gate_cell_arbiter: directed sequences, truth-table sweep, randomized model comparison.
module tb_gate_cell_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [11:0] req_op;
  logic [3:0]  req_a;
  logic [3:0]  req_b;
  logic        rsp_ready;

  logic [3:0]  req_ready,  req_ready_2;
  logic        rsp_valid,  rsp_valid_2;
  logic [1:0]  rsp_id,     rsp_id_2;
  logic        rsp_data,   rsp_data_2;
  logic        rsp_err,    rsp_err_2;
  logic        busy,       busy_2;
  logic [7:0]  op_count;
  logic [1:0]  op_count_2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int   m_cnt;
  int   m_ptr;
  bit   m_free;
  int   m_gcyc;
  int   m_id;
  logic m_data;
  logic m_err;

  always #5 clk = ~clk;

  gate_cell_arbiter #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count)
  );

  gate_cell_arbiter #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_2),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid_2),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id_2), .rsp_data(rsp_data_2), .rsp_err(rsp_err_2),
    .busy(busy_2), .op_count(op_count_2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk2(input string name, input logic [31:0] a1, input logic [31:0] a2,
                      input logic [31:0] exp);
    chk(name, a1, exp);
    chk({name, "_cnt2dut"}, a2, exp);
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk_cnt(input string name);
    chk({name, "_count"}, 32'(op_count), sat(m_cnt, 8));
    chk({name, "_count2"}, 32'(op_count_2), sat(m_cnt, 2));
  endtask

  task automatic chk_rsp(input string name, input int id, input logic d, input logic e);
    chk2({name, "_valid"}, 32'(rsp_valid), 32'(rsp_valid_2), 1);
    chk2({name, "_id"},    32'(rsp_id),    32'(rsp_id_2),    id);
    chk2({name, "_data"},  32'(rsp_data),  32'(rsp_data_2),  32'(d));
    chk2({name, "_err"},   32'(rsp_err),   32'(rsp_err_2),   32'(e));
  endtask

  // Gate semantics as {err, data}
  function automatic logic [1:0] ref_gate(input logic [2:0] op, input logic a, input logic b);
    case (op)
      3'd0: return {1'b0, a & b};
      3'd1: return {1'b0, a | b};
      3'd2: return {1'b0, ~(a | b)};
      3'd3: return {1'b0, a ^ b};
      3'd4: return {1'b0, ~a};
      3'd5: return {1'b0, a};
      default: return 2'b10;
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    next_cycle();
    next_cycle();
    rst_n  = 1'b1;
    m_cnt  = 0;
    m_ptr  = 0;
    m_free = 1'b1;
    m_gcyc = 0;
  endtask

  // One transaction from requester r with rsp_ready high; waits are bounded
  task automatic run_single(input int r, input logic [2:0] op, input logic a, input logic b,
                            output logic [1:0] id, output logic d, output logic e);
    bit ok;
    req_valid        = 4'(1) << r;
    req_op[3*r +: 3] = op;
    req_a[r]         = a;
    req_b[r]         = b;
    rsp_ready        = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (req_ready[r]) ok = 1'b1;
      else next_cycle();
    end
    chk("grant_wait", 32'(ok), 1);
    next_cycle();
    req_valid = '0;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
      else next_cycle();
    end
    chk("rsp_wait", 32'(ok), 1);
    id = rsp_id;
    d  = rsp_data;
    e  = rsp_err;
    next_cycle();
    if (ok) m_cnt++;
  endtask

  int g_id[$];
  int g_cyc[$];

  // Cycle-by-cycle comparison against a timeline model: grant -> response 2 cycles later,
  // held until a cycle with rsp_ready, next grant possible the cycle after
  task automatic run_model(input int ncyc, input bit all_held);
    int w;
    int idx;
    logic [3:0] exp_ready;
    bit exp_rv;
    logic [1:0] r;
    g_id.delete();
    g_cyc.delete();
    if (all_held) begin
      req_op = 12'($urandom);
      req_a  = 4'($urandom);
      req_b  = 4'($urandom);
    end
    for (int c = 0; c < ncyc; c++) begin
      if (all_held) begin
        req_valid = 4'hF;
        rsp_ready = 1'b1;
      end else begin
        req_valid = 4'($urandom);
        req_op    = 12'($urandom);
        req_a     = 4'($urandom);
        req_b     = 4'($urandom);
        rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      w = -1;
      if (m_free) begin
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (w < 0 && req_valid[idx]) w = idx;
        end
      end
      exp_ready = (w >= 0) ? (4'(1) << w) : 4'd0;
      exp_rv    = !m_free && (c >= m_gcyc + 2);
      chk2("m_ready", 32'(req_ready), 32'(req_ready_2), 32'(exp_ready));
      chk2("m_valid", 32'(rsp_valid), 32'(rsp_valid_2), 32'(exp_rv));
      chk2("m_busy",  32'(busy),      32'(busy_2),      32'(!m_free));
      chk_cnt("m");
      if (exp_rv) chk_rsp("m_rsp", m_id, m_data, m_err);
      if (w >= 0) begin
        m_free = 1'b0;
        m_gcyc = c;
        m_id   = w;
        r      = ref_gate(req_op[3*w +: 3], req_a[w], req_b[w]);
        m_err  = r[1];
        m_data = r[0];
        m_ptr  = (w + 1) % 4;
        g_id.push_back(w);
        g_cyc.push_back(c);
      end else if (exp_rv && rsp_ready) begin
        m_free = 1'b1;
        m_cnt++;
      end
      next_cycle();
    end
    req_valid = '0;
  endtask

  typedef struct {
    logic [2:0] op;
    logic       a;
    logic       b;
    logic       exp_d;
    logic       exp_e;
  } vec_t;

  vec_t       vecs[32];
  logic [3:0] tt[8];
  logic [3:0] tt_row;
  int         exp_order[5];
  logic [1:0] got_id;
  logic       got_d;
  logic       got_e;
  int         n_g;

  initial begin
    // Truth tables indexed by {a,b}
    tt = '{4'b1000, 4'b1110, 4'b0001, 4'b0110, 4'b0011, 4'b1100, 4'b0000, 4'b0000};
    for (int op = 0; op < 8; op++) begin
      tt_row = tt[op];
      for (int ab = 0; ab < 4; ab++) begin
        vecs[op*4 + ab] = '{3'(op), 1'(ab >> 1), 1'(ab), tt_row[ab], (op >= 6)};
      end
    end
    exp_order = '{0, 1, 2, 3, 0};

    rst_n = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    m_cnt = 0; m_ptr = 0; m_free = 1'b1; m_gcyc = 0;

    // Asynchronous reset, checked before any clock edge with requests pending
    #2;
    rst_n = 1'b0;
    req_valid = 4'hF;
    #1;
    chk2("rst_ready", 32'(req_ready), 32'(req_ready_2), 0);
    chk_rsp_zero: begin
      chk2("rst_valid", 32'(rsp_valid), 32'(rsp_valid_2), 0);
      chk2("rst_id",    32'(rsp_id),    32'(rsp_id_2),    0);
      chk2("rst_data",  32'(rsp_data),  32'(rsp_data_2),  0);
      chk2("rst_err",   32'(rsp_err),   32'(rsp_err_2),   0);
      chk2("rst_busy",  32'(busy),      32'(busy_2),      0);
    end
    chk_cnt("rst");
    do_reset();

    // Requester 2, XOR(1,0)
    req_valid = 4'b0100; req_op = 12'h0C0; req_a = 4'b0100; req_b = 4'b0000;
    @(negedge clk);
    chk2("d1_ready", 32'(req_ready), 32'(req_ready_2), 32'h4);
    chk("d1_busy_idle", 32'(busy), 0);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("d1_busy_eval", 32'(busy), 1);
    chk("d1_valid_eval", 32'(rsp_valid), 0);
    chk("d1_ready_eval", 32'(req_ready), 0);
    next_cycle();
    @(negedge clk);
    chk_rsp("d1_rsp", 2, 1'b1, 1'b0);
    next_cycle();
    m_cnt = 1;
    @(negedge clk);
    chk("d1_valid_after", 32'(rsp_valid), 0);
    chk("d1_busy_after", 32'(busy), 0);
    chk_cnt("d1");
    next_cycle();

    // Opcode x operand sweep from requester 0
    for (int i = 0; i < 32; i++) begin
      run_single(0, vecs[i].op, vecs[i].a, vecs[i].b, got_id, got_d, got_e);
      chk($sformatf("sweep_op%0d_a%0d_b%0d_data", vecs[i].op, vecs[i].a, vecs[i].b),
          32'(got_d), 32'(vecs[i].exp_d));
      chk($sformatf("sweep_op%0d_a%0d_b%0d_err", vecs[i].op, vecs[i].a, vecs[i].b),
          32'(got_e), 32'(vecs[i].exp_e));
      chk("sweep_id", 32'(got_id), 0);
    end
    @(negedge clk);
    chk_cnt("sweep");
    next_cycle();

    // All requesters held valid: order and spacing of grants
    do_reset();
    run_model(20, 1'b1);
    n_g = g_id.size();
    chk("rr_grant_count", 32'(n_g >= 5), 1);
    for (int i = 0; i < 5 && i < n_g; i++) begin
      chk($sformatf("rr_order_%0d", i), 32'(g_id[i]), 32'(exp_order[i]));
      if (i > 0) chk($sformatf("rr_spacing_%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 3);
    end

    // Randomized traffic with back-pressure
    do_reset();
    run_model(400, 1'b0);

    // Response stalled for 10 cycles while others keep requesting
    do_reset();
    req_valid = 4'b0010; req_op = 12'h028; req_a = 4'b0010; req_b = 4'b0000; rsp_ready = 1'b0;
    @(negedge clk);
    chk("st_grant", 32'(req_ready), 32'h2);
    next_cycle();
    req_valid = 4'hF;
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_rsp($sformatf("st_hold%0d", i), 1, 1'b1, 1'b0);
      chk($sformatf("st_ready%0d", i), 32'(req_ready), 0);
      chk($sformatf("st_busy%0d", i), 32'(busy), 1);
      chk_cnt("st_hold");
      next_cycle();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    chk("st_valid_hs", 32'(rsp_valid), 1);
    next_cycle();
    m_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("st_valid_post%0d", i), 32'(rsp_valid), 0);
      chk_cnt("st_post");
      next_cycle();
    end

    // Reset asserted while in EVAL
    do_reset();
    req_valid = 4'b0001; req_op = 12'h000; req_a = 4'b0001; req_b = 4'b0001;
    @(negedge clk);
    chk("re_grant", 32'(req_ready), 32'h1);
    next_cycle();
    req_valid = '0;
    @(negedge clk);
    chk("re_busy_eval", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk2("re_valid", 32'(rsp_valid), 32'(rsp_valid_2), 0);
    chk2("re_busy",  32'(busy),      32'(busy_2),      0);
    chk_cnt("re");
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("re_quiet_valid%0d", i), 32'(rsp_valid), 0);
      chk($sformatf("re_quiet_busy%0d", i), 32'(busy), 0);
      chk_cnt("re_quiet");
      next_cycle();
    end

    // Five responses: 8-bit counter reaches 5, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      run_single(i % 4, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), got_id, got_d, got_e);
      chk($sformatf("sat_id%0d", i), 32'(got_id), 32'(i % 4));
      @(negedge clk);
      chk_cnt($sformatf("sat%0d", i));
      next_cycle();
    end
    chk("sat_final", 32'(op_count_2), 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
